// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the RAM.
//   p0_* : processor load/store port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   p1_* : VGA tile/sprite fetch port (same set as p0)
//   mem_*: registered command to the single-port RAM, mem_q is its read data
// The arbiter connects through the slave modport; whatever drives the
// requests and models the RAM uses the master modport.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_q
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port game data memory.
//   clock : system clock, everything on the rising edge
//   reset : synchronous, active-high
//   bus   : dmem_port_arbiter_if.slave
//           p0 = processor load/store, p1 = VGA fetch; mem_* = RAM command,
//           mem_q = RAM read data (valid MEM_LAT cycles after mem_addr).
// One command per cycle is granted (combinationally, from req), registered
// onto mem_*, and reads are tracked by a {valid, owner} tag pipeline so the
// read data is steered back to the right port 1+MEM_LAT cycles after grant.
// ARB_MODE 0: round-robin. ARB_MODE 1: port 1 first, but port 0 wins once
// after MAX_WAIT consecutive denied cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 8
) (
  input logic               clock,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int PIPE_D = 1 + MEM_LAT;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic              rr_p1_reg;   // 1: port 1 wins the next contended cycle
  logic [WAIT_W-1:0] wait0_reg;   // consecutive cycles port 0 was denied
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              mem_wren_reg;

  logic grant0;
  logic grant1;
  logic p1_first;

  // Kept to a couple of gate levels: the tie-break bit is a register, so
  // req -> gnt is just the contention mux plus the reset gate.
  always_comb begin
    p1_first = (ARB_MODE == 0) ? rr_p1_reg : (wait0_reg < WAIT_W'(MAX_WAIT));
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (!reset) begin
      if (bus.p0_req && bus.p1_req) begin
        grant1 = p1_first;
        grant0 = !p1_first;
      end else begin
        grant0 = bus.p0_req;
        grant1 = bus.p1_req;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_p1_reg     <= 1'b0;
      wait0_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wren_reg  <= 1'b0;
    end else begin
      if (grant0) begin
        rr_p1_reg <= 1'b1;
      end else if (grant1) begin
        rr_p1_reg <= 1'b0;
      end

      if (grant0) begin
        wait0_reg <= '0;
      end else if (bus.p0_req && (wait0_reg < WAIT_W'(MAX_WAIT))) begin
        wait0_reg <= wait0_reg + 1'b1;
      end

      // Address and data only move on a grant so an idle RAM port keeps
      // presenting the last address.
      if (grant1) begin
        mem_addr_reg  <= bus.p1_addr;
        mem_wdata_reg <= bus.p1_wdata;
        mem_wren_reg  <= bus.p1_we;
      end else if (grant0) begin
        mem_addr_reg  <= bus.p0_addr;
        mem_wdata_reg <= bus.p0_wdata;
        mem_wren_reg  <= bus.p0_we;
      end else begin
        mem_wren_reg  <= 1'b0;
      end
    end
  end

  // Read-return tag pipeline: stage 0 is loaded at the grant edge, the last
  // stage lines up with mem_q for that command.
  logic tag_valid_in;
  logic tag_owner_in;
  logic tag_valid_out;
  logic tag_owner_out;

  assign tag_valid_in = (grant0 && !bus.p0_we) || (grant1 && !bus.p1_we);
  assign tag_owner_in = grant1;

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_D; gi++) begin : g_tag
      logic valid_reg;
      logic owner_reg;
      logic valid_prev;
      logic owner_prev;

      if (gi == 0) begin : g_head
        assign valid_prev = tag_valid_in;
        assign owner_prev = tag_owner_in;
      end else begin : g_body
        assign valid_prev = g_tag[gi-1].valid_reg;
        assign owner_prev = g_tag[gi-1].owner_reg;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          valid_reg <= 1'b0;
          owner_reg <= 1'b0;
        end else begin
          valid_reg <= valid_prev;
          owner_reg <= owner_prev;
        end
      end
    end
  endgenerate

  assign tag_valid_out = g_tag[PIPE_D-1].valid_reg;
  assign tag_owner_out = g_tag[PIPE_D-1].owner_reg;

  // Reset also gates the return path so nothing escapes in the cycle reset
  // is first seen.
  logic [DATA_W-1:0] rdata_bus;
  assign rdata_bus = (tag_valid_out && !reset) ? bus.mem_q : '0;

  assign bus.p0_gnt    = grant0;
  assign bus.p1_gnt    = grant1;
  assign bus.p0_rvalid = tag_valid_out && !tag_owner_out && !reset;
  assign bus.p1_rvalid = tag_valid_out && tag_owner_out && !reset;
  assign bus.p0_rdata  = rdata_bus;
  assign bus.p1_rdata  = rdata_bus;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_wren  = mem_wren_reg;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: dut_a runs round-robin, dut_b fixed priority.
// Read results are predicted at grant time into a scoreboard and compared
// when rvalid appears; a shadow memory model supplies the expected data.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1),
                      .ARB_MODE(0), .MAX_WAIT(8))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1),
                      .ARB_MODE(1), .MAX_WAIT(8))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ram_a[int];
  logic [31:0] model[int];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;

  logic        p_req[2];
  logic        p_we[2];
  logic [16:0] p_addr[2];
  logic [31:0] p_wdata[2];

  function automatic logic [31:0] pat(int a);
    return 32'h5A00_0000 ^ 32'(a);
  endfunction

  function automatic logic [31:0] model_rd(int a);
    return model.exists(a) ? model[a] : pat(a);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous RAM models, 1-cycle read latency.
  always @(posedge clock) begin : ram_a_blk
    int          a;
    logic [31:0] q;
    a = int'(bus_a.mem_addr);
    q = ram_a.exists(a) ? ram_a[a] : pat(a);
    if (bus_a.mem_wren === 1'b1) ram_a[a] = bus_a.mem_wdata;
    bus_a.mem_q <= q;
  end

  always @(posedge clock) bus_b.mem_q <= pat(int'(bus_b.mem_addr));

  // Read-return monitor for dut_a.
  always @(negedge clock) begin : mon_a
    exp_t e;
    if (bus_a.p0_rvalid === 1'b1 || bus_a.p1_rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL rvalid_unexpected: got p0=%b p1=%b data=%h, required none",
                 bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.p0_rdata);
      end else begin
        e = sb.pop_front();
        if (bus_a.p1_rvalid !== e.port || bus_a.p0_rvalid === bus_a.p1_rvalid ||
            bus_a.p0_rdata !== e.data || cyc != e.due)
          $display("FAIL rvalid_match: got p0=%b p1=%b data=%h cyc=%0d, required port %0d data=%h cyc=%0d",
                   bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.p0_rdata, cyc, e.port, e.data, e.due);
        else begin
          passed++;
          $display("read return: port %0d data=%h cycle %0d", e.port, e.data, cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      $display("FAIL rvalid_missing: got no rvalid, required port %0d data=%h at cyc %0d",
               sb[0].port, sb[0].data, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ports(input bit sel_b);
    bus_a.p0_req   = sel_b ? 1'b0 : p_req[0];
    bus_a.p1_req   = sel_b ? 1'b0 : p_req[1];
    bus_b.p0_req   = sel_b ? p_req[0] : 1'b0;
    bus_b.p1_req   = sel_b ? p_req[1] : 1'b0;
    bus_a.p0_we    = p_we[0];    bus_b.p0_we    = p_we[0];
    bus_a.p1_we    = p_we[1];    bus_b.p1_we    = p_we[1];
    bus_a.p0_addr  = p_addr[0];  bus_b.p0_addr  = p_addr[0];
    bus_a.p1_addr  = p_addr[1];  bus_b.p1_addr  = p_addr[1];
    bus_a.p0_wdata = p_wdata[0]; bus_b.p0_wdata = p_wdata[0];
    bus_a.p1_wdata = p_wdata[1]; bus_b.p1_wdata = p_wdata[1];
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [16:0] addr, input logic [31:0] wdata);
    p_req[p] = req; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
  endtask

  // Leaves the bench just after a rising edge with reset low.
  task automatic apply_reset();
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    reset = 1'b1;
    sb.delete();
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_port(0, 1'b1, 1'b0, 17'h00010, '0);
    set_port(1, 1'b1, 1'b0, 17'h00020, '0);
    drive_ports(1'b0);
    bus_b.p0_req = 1'b1; bus_b.p1_req = 1'b1;
    repeat (3) next_cycle();
    @(negedge clock);
    checks++;
    if ({bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.mem_wren,
         bus_a.mem_addr, bus_a.mem_wdata, bus_a.p0_rdata, bus_a.p1_rdata} !== '0)
      $display("FAIL reset_outputs_a: got gnt=%b%b rv=%b%b wren=%b addr=%h wdata=%h rdata=%h, required all 0",
               bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.mem_wren,
               bus_a.mem_addr, bus_a.mem_wdata, bus_a.p0_rdata);
    else passed++;
    checks++;
    if ({bus_b.p0_gnt, bus_b.p1_gnt, bus_b.mem_wren, bus_b.mem_addr} !== '0)
      $display("FAIL reset_outputs_b: got gnt=%b%b wren=%b addr=%h, required all 0",
               bus_b.p0_gnt, bus_b.p1_gnt, bus_b.mem_wren, bus_b.mem_addr);
    else passed++;
  endtask

  task automatic test_single_read();
    apply_reset();
    ram_a[16] = 32'hDEADBEEF;
    model[16] = 32'hDEADBEEF;
    set_port(0, 1'b1, 1'b0, 17'h00010, '0);
    drive_ports(1'b0);
    @(negedge clock);
    checks++;
    if ({bus_a.p1_gnt, bus_a.p0_gnt} !== 2'b01)
      $display("FAIL single_read_gnt: got p1/p0=%b%b, required 01", bus_a.p1_gnt, bus_a.p0_gnt);
    else passed++;
    sb.push_back('{1'b0, 32'hDEADBEEF, cyc + 2});
    next_cycle();
    set_port(0, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    @(negedge clock);
    checks++;
    if (bus_a.mem_addr !== 17'h00010 || bus_a.mem_wren !== 1'b0)
      $display("FAIL single_read_issue: got addr=%h wren=%b, required addr=00010 wren=0",
               bus_a.mem_addr, bus_a.mem_wren);
    else passed++;
    repeat (3) next_cycle();
  endtask

  task automatic test_round_robin();
    logic [16:0] prev_addr;
    logic [1:0]  exp;
    int          n[2];
    apply_reset();
    n[0] = 0; n[1] = 0;
    prev_addr = '0;
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 1'b0, 17'h00100 + 17'(n[0]), '0);
      set_port(1, 1'b1, 1'b0, 17'h00200 + 17'(n[1]), '0);
      drive_ports(1'b0);
      @(negedge clock);
      exp = (i % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if ({bus_a.p1_gnt, bus_a.p0_gnt} !== exp)
        $display("FAIL rr_gnt[%0d]: got p1/p0=%b%b, required %b", i, bus_a.p1_gnt, bus_a.p0_gnt, exp);
      else passed++;
      if (i > 0) begin
        checks++;
        if (bus_a.mem_addr !== prev_addr)
          $display("FAIL rr_mem_addr[%0d]: got %h, required %h", i, bus_a.mem_addr, prev_addr);
        else passed++;
      end
      prev_addr = p_addr[exp[1]];
      sb.push_back('{exp[1], model_rd(int'(p_addr[exp[1]])), cyc + 2});
      n[exp[1]]++;
      next_cycle();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    repeat (3) next_cycle();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp;
    apply_reset();
    set_port(0, 1'b1, 1'b0, 17'h00400, '0);
    set_port(1, 1'b1, 1'b0, 17'h00500, '0);
    drive_ports(1'b1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      exp = (i % 9 == 8) ? 2'b01 : 2'b10;
      checks++;
      if ({bus_b.p1_gnt, bus_b.p0_gnt} !== exp)
        $display("FAIL fixed_prio_gnt[%0d]: got p1/p0=%b%b, required %b", i, bus_b.p1_gnt, bus_b.p0_gnt, exp);
      else passed++;
      next_cycle();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    repeat (3) next_cycle();
  endtask

  task automatic test_write_then_read();
    apply_reset();
    set_port(0, 1'b1, 1'b1, 17'h1FFFF, 32'h12345678);
    drive_ports(1'b0);
    @(negedge clock);
    checks++;
    if ({bus_a.p1_gnt, bus_a.p0_gnt} !== 2'b01)
      $display("FAIL wr_gnt: got p1/p0=%b%b, required 01", bus_a.p1_gnt, bus_a.p0_gnt);
    else passed++;
    model[32'h1FFFF] = 32'h12345678;
    next_cycle();
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b1, 1'b0, 17'h1FFFF, '0);
    drive_ports(1'b0);
    @(negedge clock);
    checks++;
    if ({bus_a.p1_gnt, bus_a.mem_wren, bus_a.mem_addr, bus_a.mem_wdata} !== {1'b1, 1'b1, 17'h1FFFF, 32'h12345678})
      $display("FAIL wr_issue: got gnt1=%b wren=%b addr=%h wdata=%h, required 1 1 1ffff 12345678",
               bus_a.p1_gnt, bus_a.mem_wren, bus_a.mem_addr, bus_a.mem_wdata);
    else passed++;
    sb.push_back('{1'b1, 32'h12345678, cyc + 2});
    next_cycle();
    set_port(1, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    @(negedge clock);
    checks++;
    if (bus_a.mem_wren !== 1'b0 || bus_a.mem_addr !== 17'h1FFFF)
      $display("FAIL wr_one_cycle: got wren=%b addr=%h, required wren=0 addr=1ffff",
               bus_a.mem_wren, bus_a.mem_addr);
    else passed++;
    repeat (3) next_cycle();
  endtask

  task automatic test_back_to_back();
    bit         rr_p1;
    bit         w1;
    logic [1:0] exp;
    apply_reset();
    rr_p1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(3) != 0)
          set_port(p, 1'b1, 1'($urandom_range(1)), 17'h00300 + 17'($urandom_range(3)), $urandom);
      drive_ports(1'b0);
      @(negedge clock);
      w1  = (p_req[0] && p_req[1]) ? rr_p1 : bit'(p_req[1]);
      exp = (p_req[0] || p_req[1]) ? (w1 ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({bus_a.p1_gnt, bus_a.p0_gnt} !== exp)
        $display("FAIL b2b_gnt[%0d]: got p1/p0=%b%b, required %b", i, bus_a.p1_gnt, bus_a.p0_gnt, exp);
      else passed++;
      if (exp != 2'b00) begin
        if (p_we[w1]) model[int'(p_addr[w1])] = p_wdata[w1];
        else sb.push_back('{w1, model_rd(int'(p_addr[w1])), cyc + 2});
        rr_p1 = !w1;
        p_req[w1] = 1'b0;
      end
      next_cycle();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    set_port(1, 1'b1, 1'b0, 17'h00020, '0);
    drive_ports(1'b0);
    @(negedge clock);
    checks++;
    if (bus_a.p1_gnt !== 1'b1)
      $display("FAIL mid_reset_gnt: got %b, required 1", bus_a.p1_gnt);
    else passed++;
    next_cycle();
    // The read just granted must never come back.
    reset = 1'b1;
    sb.delete();
    set_port(0, 1'b1, 1'b0, 17'h00030, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    next_cycle();
    @(negedge clock);
    checks++;
    if ({bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.mem_wren,
         bus_a.mem_addr, bus_a.p1_rdata} !== '0)
      $display("FAIL mid_reset_outputs: got gnt=%b%b rv=%b%b wren=%b addr=%h rdata=%h, required all 0",
               bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.mem_wren,
               bus_a.mem_addr, bus_a.p1_rdata);
    else passed++;
    next_cycle();
    reset = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    repeat (4) next_cycle();
  endtask

  task automatic test_idle();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 17'h00055, '0);
    drive_ports(1'b0);
    @(negedge clock);
    sb.push_back('{1'b0, model_rd(32'h55), cyc + 2});
    next_cycle();
    set_port(0, 1'b0, 1'b0, '0, '0);
    drive_ports(1'b0);
    repeat (3) next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.mem_wren} !== 5'b0 ||
          bus_a.mem_addr !== 17'h00055)
        $display("FAIL idle[%0d]: got gnt=%b%b rv=%b%b wren=%b addr=%h, required zeros and addr 00055",
                 i, bus_a.p0_gnt, bus_a.p1_gnt, bus_a.p0_rvalid, bus_a.p1_rvalid,
                 bus_a.mem_wren, bus_a.mem_addr);
      else passed++;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d outstanding reads, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
